jogo_senha_controle: RTL and testbench
======================================

# jogo_senha_controle

Sequential controller for the two-player code-guessing game; it drives the 4-bit digit and 4-bit state-code inputs of the seven-segment display mapper directly downstream. Player 1 enters a 4-digit secret. Player 2 then enters 4-digit guesses until one of three things happens: a full match, exhausted attempts, or a restart. Each guess is scored by positional matches and shown as a result state code for a fixed time.

## Interface
- Parameters:
  - `MAX_TENTATIVAS`, default 3: number of guesses allowed (1–3).
  - `TEMPO_EXIBICAO`, default 25_000_000: clock cycles a non-terminal result is displayed (≥2).
- Ports:
  - `clock` input 1: single system clock, rising edge.
  - `reset_n` input 1: asynchronous, active-low reset.
  - `entrada` input 4: digit from switches, BCD.
  - `confirma` input 1: one-cycle strobe, already debounced; captures `entrada`.
  - `reiniciar` input 1: synchronous restart strobe.
  - `digito` output 4: digit to display.
  - `estado` output 4: state code to display mapper.
  - `acertos` output 3: positional matches of the last scored guess (0–4).
  - `tentativas_restantes` output 2: guesses remaining.
- One clock; reset is asynchronous and active-low.

## Operation
- State codes on `estado`, all registered:
  - CADASTRO = 4'b0001
  - PALPITE = 4'b0010
  - COMPARA = 4'b0011
  - SUCESSO_TOTAL = 4'b0110
  - SUCESSO_PARCIAL = 4'b1101
  - FALHA = 4'b1110
- Only these codes are legal.
- Digit capture, in CADASTRO and PALPITE:
  - `confirma`=1 with `entrada`≤9: store the digit in position `indice` (0..3), set `digito`=`entrada`, increment `indice`.
  - `entrada`>9: the strobe is ignored, with no state change.
- CADASTRO: after the 4th accepted digit, clear `indice`, set `digito`=4'hF, go to PALPITE.
- PALPITE: after the 4th accepted digit, go to COMPARA.
- COMPARA, 1 cycle:
  - `acertos` = count of positions where guess equals secret.
  - Decrement `tentativas_restantes`.
  - Next state:
    - `acertos`=4: SUCESSO_TOTAL.
    - Otherwise, if the decremented count is 0: FALHA (terminal).
    - Otherwise, if `acertos`≥1: SUCESSO_PARCIAL.
    - Otherwise: FALHA (timed).
- Timed results (SUCESSO_PARCIAL, or FALHA with attempts remaining):
  - Load the timer with TEMPO_EXIBICAO−1 on entry.
  - Count down to 0, then go to PALPITE.
  - On that transition: clear `indice`, set `digito`=4'hF, keep `acertos`.
- Terminal results: SUCESSO_TOTAL and FALHA with `tentativas_restantes`=0 hold until `reiniciar` or reset.
- `confirma` is ignored in COMPARA and in all result states.
- `reiniciar`=1 in any state:
  - Next cycle is CADASTRO.
  - Clear `indice`, secret, guess and `acertos`; set `digito`=4'hF, timer=0, `tentativas_restantes`=MAX_TENTATIVAS.
  - Takes priority over a simultaneous `confirma` and over timer expiry.
- Reset values, async on `reset_n`=0:
  - `estado`=0001, `digito`=4'hF, `acertos`=0, `tentativas_restantes`=MAX_TENTATIVAS.
  - Secret, guess, `indice` and timer are all 0.
- Reset asserted mid-entry or mid-display discards all progress.

## Timing
- All outputs are registered and change only on the rising `clock` edge, except on asynchronous reset.
- Digit strobe at edge N: `digito` and `indice` are updated at N+1.
- Transition rules:
  - 4th digit at edge N: `estado` leaves the entry state at N+1.
  - COMPARA lasts exactly one cycle; the result state and `acertos` are valid at N+2 relative to the 4th guess digit.
  - A timed result occupies exactly TEMPO_EXIBICAO cycles, then PALPITE.
- `reiniciar` at edge N: `estado`=CADASTRO at N+1.
- `tentativas_restantes` decrements in the COMPARA cycle; the new value is visible together with the result state.
- Back-to-back `confirma` strobes on consecutive cycles are all accepted.

## Test plan
- Reset mid-entry: after 2 secret digits, pulse `reset_n` low → `estado`=0001, `digito`=F, `tentativas_restantes`=3; the next 4 digits form a fresh secret.
- Invalid digit: in CADASTRO, `entrada`=4'hA with `confirma` → no change to `digito`/`indice`; the valid sequence 1,2,3,4 then reaches PALPITE.
- Full success (TEMPO_EXIBICAO=4):
  - Stimulus: secret 1234, guess 1234.
  - COMPARA lasts 1 cycle; then `estado`=0110, `acertos`=4, `tentativas_restantes`=2.
  - The state holds for 20 cycles; `reiniciar` returns to 0001.
- Partial then timed fail:
  - Stimulus: secret 1234; guess 1299, then guess 5678.
  - First guess: `estado`=1101, `acertos`=2, held exactly 4 cycles, then 0010 with `digito`=F.
  - Second guess: 1110 with `acertos`=0 for 4 cycles, then 0010.
- Attempts exhausted: three wrong guesses with MAX_TENTATIVAS=3 → after the third, `estado`=1110 is held indefinitely, `tentativas_restantes`=0, and `confirma` is ignored.
- Priority: `reiniciar` and `confirma` in the same cycle during PALPITE, and `reiniciar` on the final timer cycle → CADASTRO next cycle in both cases, with no digit captured.

Source files
------------

// File: rtl/jogo_senha_controle_if.sv
// Player-facing bus of the code-guessing controller: switch/strobe inputs and
// display-side outputs.
interface jogo_senha_controle_if;
   logic [3:0] entrada;
   logic       confirma;
   logic       reiniciar;
   logic [3:0] digito;
   logic [3:0] estado;
   logic [2:0] acertos;
   logic [1:0] tentativas_restantes;

   modport master (
      output entrada, confirma, reiniciar,
      input  digito, estado, acertos, tentativas_restantes
   );

   modport slave (
      input  entrada, confirma, reiniciar,
      output digito, estado, acertos, tentativas_restantes
   );
endinterface

// File: rtl/jogo_senha_controle.sv
// Two-player code-guessing controller: captures a 4-digit secret, scores 4-digit
// guesses by positional matches and sequences the result codes for the display.
module jogo_senha_controle #(
   parameter int unsigned MAX_TENTATIVAS = 3,
   parameter int unsigned TEMPO_EXIBICAO = 25_000_000
) (
   input logic                  clock,
   input logic                  reset_n,
   jogo_senha_controle_if.slave bus
);

   localparam int unsigned TIMER_W   = $clog2(TEMPO_EXIBICAO);
   localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TEMPO_EXIBICAO - 1);
   localparam logic [1:0]  TENT_INI  = 2'(MAX_TENTATIVAS);
   localparam logic [3:0]  DIG_APAGADO = 4'hF;

   typedef enum logic [3:0] {
      CADASTRO        = 4'b0001,
      PALPITE         = 4'b0010,
      COMPARA         = 4'b0011,
      SUCESSO_TOTAL   = 4'b0110,
      SUCESSO_PARCIAL = 4'b1101,
      FALHA           = 4'b1110
   } estado_t;

   estado_t            state_q, state_d;
   logic [1:0]         indice_q, indice_d;
   logic [3:0][3:0]    secret_q, secret_d;
   logic [3:0][3:0]    guess_q, guess_d;
   logic [3:0]         digito_q, digito_d;
   logic [2:0]         acertos_q, acertos_d;
   logic [1:0]         tent_q, tent_d;
   logic [TIMER_W-1:0] timer_q, timer_d;

   logic       digito_valido;
   logic [2:0] acertos_c;
   logic [1:0] tent_dec;

   // Next-state and datapath update; restart overrides every other event.
   always_comb begin
      state_d   = state_q;
      indice_d  = indice_q;
      secret_d  = secret_q;
      guess_d   = guess_q;
      digito_d  = digito_q;
      acertos_d = acertos_q;
      tent_d    = tent_q;
      timer_d   = timer_q;

      digito_valido = bus.confirma && (bus.entrada <= 4'd9);
      tent_dec      = tent_q - 2'd1;
      acertos_c     = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (guess_q[i] == secret_q[i]) acertos_c = acertos_c + 3'd1;
      end

      if (bus.reiniciar) begin
         state_d   = CADASTRO;
         indice_d  = 2'd0;
         secret_d  = '0;
         guess_d   = '0;
         digito_d  = DIG_APAGADO;
         acertos_d = 3'd0;
         tent_d    = TENT_INI;
         timer_d   = '0;
      end else begin
         unique case (state_q)
            CADASTRO: begin
               if (digito_valido) begin
                  secret_d[indice_q] = bus.entrada;
                  digito_d           = bus.entrada;
                  indice_d           = indice_q + 2'd1;
                  if (indice_q == 2'd3) begin
                     digito_d = DIG_APAGADO;
                     state_d  = PALPITE;
                  end
               end
            end
            PALPITE: begin
               if (digito_valido) begin
                  guess_d[indice_q] = bus.entrada;
                  digito_d          = bus.entrada;
                  indice_d          = indice_q + 2'd1;
                  if (indice_q == 2'd3) state_d = COMPARA;
               end
            end
            COMPARA: begin
               acertos_d = acertos_c;
               tent_d    = tent_dec;
               if (acertos_c == 3'd4) begin
                  state_d = SUCESSO_TOTAL;
               end else if (tent_dec == 2'd0) begin
                  state_d = FALHA;
               end else begin
                  state_d = (acertos_c != 3'd0) ? SUCESSO_PARCIAL : FALHA;
                  timer_d = TIMER_LOAD;
               end
            end
            SUCESSO_PARCIAL, FALHA: begin
               // FALHA with no attempts left is terminal and simply holds.
               if (!(state_q == FALHA && tent_q == 2'd0)) begin
                  if (timer_q == '0) begin
                     state_d  = PALPITE;
                     indice_d = 2'd0;
                     digito_d = DIG_APAGADO;
                  end else begin
                     timer_d = timer_q - TIMER_W'(1);
                  end
               end
            end
            SUCESSO_TOTAL: begin
               state_d = SUCESSO_TOTAL;
            end
            default: begin
               state_d = CADASTRO;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= CADASTRO;
         indice_q  <= 2'd0;
         secret_q  <= '0;
         guess_q   <= '0;
         digito_q  <= DIG_APAGADO;
         acertos_q <= 3'd0;
         tent_q    <= TENT_INI;
         timer_q   <= '0;
      end else begin
         state_q   <= state_d;
         indice_q  <= indice_d;
         secret_q  <= secret_d;
         guess_q   <= guess_d;
         digito_q  <= digito_d;
         acertos_q <= acertos_d;
         tent_q    <= tent_d;
         timer_q   <= timer_d;
      end
   end

   assign bus.digito               = digito_q;
   assign bus.estado               = state_q;
   assign bus.acertos              = acertos_q;
   assign bus.tentativas_restantes = tent_q;

endmodule

// File: tb/tb_jogo_senha_controle.sv
// Self-checking bench for jogo_senha_controle: directed game scenarios plus a
// randomized run checked against a per-cycle behavioural model of the game rules.
module tb_jogo_senha_controle;

   localparam int MAX_T  = 3;
   localparam int TEMPO  = 4;
   localparam logic [3:0] C_CAD = 4'b0001, C_PAL = 4'b0010, C_CMP = 4'b0011,
                          C_ST  = 4'b0110, C_SP  = 4'b1101, C_FA  = 4'b1110;

   logic clock;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   jogo_senha_controle_if bus ();

   jogo_senha_controle #(.MAX_TENTATIVAS(MAX_T), .TEMPO_EXIBICAO(TEMPO)) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Behavioural game model.
   logic [3:0] m_estado, m_digito;
   logic [3:0] m_sec[4];
   logic [3:0] m_gue[4];
   int         m_idx, m_timer, m_acertos, m_tent;

   task automatic model_clear();
      m_estado = C_CAD; m_digito = 4'hF; m_acertos = 0; m_tent = MAX_T;
      m_idx = 0; m_timer = 0;
      for (int i = 0; i < 4; i++) begin m_sec[i] = 4'd0; m_gue[i] = 4'd0; end
   endtask

   task automatic model_step(input logic [3:0] e, input logic c, input logic r);
      int hits;
      if (r) begin
         model_clear();
      end else if (m_estado == C_CAD || m_estado == C_PAL) begin
         if (c && e <= 4'd9) begin
            if (m_estado == C_CAD) m_sec[m_idx] = e; else m_gue[m_idx] = e;
            m_digito = e;
            m_idx++;
            if (m_idx == 4) begin
               m_idx = 0;
               if (m_estado == C_CAD) begin m_digito = 4'hF; m_estado = C_PAL; end
               else m_estado = C_CMP;
            end
         end
      end else if (m_estado == C_CMP) begin
         hits = 0;
         for (int i = 0; i < 4; i++) if (m_gue[i] == m_sec[i]) hits++;
         m_acertos = hits;
         m_tent--;
         if (hits == 4) m_estado = C_ST;
         else if (m_tent == 0) m_estado = C_FA;
         else begin
            m_estado = (hits > 0) ? C_SP : C_FA;
            m_timer  = TEMPO - 1;
         end
      end else if (m_estado == C_SP || (m_estado == C_FA && m_tent > 0)) begin
         if (m_timer == 0) begin m_estado = C_PAL; m_idx = 0; m_digito = 4'hF; end
         else m_timer--;
      end
   endtask

   // One clock: drive inputs, advance model on the edge, settle 1 time unit.
   task automatic cyc(input logic [3:0] e, input logic c, input logic r);
      bus.entrada = e; bus.confirma = c; bus.reiniciar = r;
      @(posedge clock);
      model_step(e, c, r);
      #1;
      bus.confirma = 1'b0; bus.reiniciar = 1'b0;
   endtask

   task automatic enter4(input logic [15:0] v);
      for (int i = 3; i >= 0; i--) cyc(v[i*4 +: 4], 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      bus.entrada = 4'd0; bus.confirma = 1'b0; bus.reiniciar = 1'b0;
      reset_n = 1'b0;
      model_clear();
      #12;
      checks++; if (bus.estado !== C_CAD) begin errors++; $display("FAIL reset_estado got %h want %h", bus.estado, C_CAD); end
      checks++; if (bus.digito !== 4'hF) begin errors++; $display("FAIL reset_digito got %h want f", bus.digito); end
      checks++; if (bus.acertos !== 3'd0) begin errors++; $display("FAIL reset_acertos got %0d want 0", bus.acertos); end
      checks++; if (bus.tentativas_restantes !== 2'(MAX_T)) begin errors++; $display("FAIL reset_tent got %0d want %0d", bus.tentativas_restantes, MAX_T); end
      @(posedge clock); #1;
      reset_n = 1'b1;
   endtask

   task automatic test_reset_mid_entry();
      cyc(4'd9, 1'b1, 1'b0);
      cyc(4'd8, 1'b1, 1'b0);
      checks++; if (bus.digito !== 4'd8) begin errors++; $display("FAIL mid_entry_digito got %h want 8", bus.digito); end
      reset_n = 1'b0;
      model_clear();
      #2;
      checks++; if (bus.estado !== C_CAD || bus.digito !== 4'hF || bus.tentativas_restantes !== 2'd3)
         begin errors++; $display("FAIL mid_reset got estado=%h digito=%h tent=%0d want 1 f 3", bus.estado, bus.digito, bus.tentativas_restantes); end
      #2 reset_n = 1'b1;
      enter4(16'h5678);
      checks++; if (bus.estado !== C_PAL) begin errors++; $display("FAIL fresh_secret_pal got %h want %h", bus.estado, C_PAL); end
      enter4(16'h5678);
      cyc(4'd0, 1'b0, 1'b0);
      checks++; if (bus.estado !== C_ST || bus.acertos !== 3'd4)
         begin errors++; $display("FAIL fresh_secret_match got estado=%h acertos=%0d want 6 4", bus.estado, bus.acertos); end
   endtask

   task automatic test_invalid_digit();
      cyc(4'd0, 1'b0, 1'b1);
      cyc(4'hA, 1'b1, 1'b0);
      checks++; if (bus.digito !== 4'hF || bus.estado !== C_CAD)
         begin errors++; $display("FAIL invalid_digit got digito=%h estado=%h want f 1", bus.digito, bus.estado); end
      cyc(4'd1, 1'b1, 1'b0); cyc(4'd2, 1'b1, 1'b0); cyc(4'd3, 1'b1, 1'b0);
      checks++; if (bus.estado !== C_CAD || bus.digito !== 4'd3)
         begin errors++; $display("FAIL invalid_idx got estado=%h digito=%h want 1 3", bus.estado, bus.digito); end
      cyc(4'd4, 1'b1, 1'b0);
      checks++; if (bus.estado !== C_PAL || bus.digito !== 4'hF)
         begin errors++; $display("FAIL invalid_then_pal got estado=%h digito=%h want 2 f", bus.estado, bus.digito); end
   endtask

   task automatic test_full_success();
      cyc(4'd0, 1'b0, 1'b1);
      enter4(16'h1234);
      enter4(16'h1234);
      checks++; if (bus.estado !== C_CMP) begin errors++; $display("FAIL full_compara got %h want %h", bus.estado, C_CMP); end
      cyc(4'd0, 1'b0, 1'b0);
      checks++; if (bus.estado !== C_ST || bus.acertos !== 3'd4 || bus.tentativas_restantes !== 2'd2)
         begin errors++; $display("FAIL full_result got estado=%h acertos=%0d tent=%0d want 6 4 2", bus.estado, bus.acertos, bus.tentativas_restantes); end
      for (int k = 0; k < 20; k++) begin
         cyc(4'd1, 1'b1, 1'b0);
         checks++; if (bus.estado !== C_ST) begin errors++; $display("FAIL full_hold[%0d] got %h want %h", k, bus.estado, C_ST); end
      end
      cyc(4'd0, 1'b0, 1'b1);
      checks++; if (bus.estado !== C_CAD || bus.tentativas_restantes !== 2'd3 || bus.acertos !== 3'd0 || bus.digito !== 4'hF)
         begin errors++; $display("FAIL full_restart got estado=%h tent=%0d acertos=%0d digito=%h want 1 3 0 f", bus.estado, bus.tentativas_restantes, bus.acertos, bus.digito); end
   endtask

   task automatic test_partial_then_fail();
      cyc(4'd0, 1'b0, 1'b1);
      enter4(16'h1234);
      enter4(16'h1299);
      checks++; if (bus.estado !== C_CMP) begin errors++; $display("FAIL partial_compara got %h want %h", bus.estado, C_CMP); end
      for (int k = 0; k < TEMPO; k++) begin
         cyc(4'd1, 1'b1, 1'b0);
         checks++; if (bus.estado !== C_SP || bus.acertos !== 3'd2 || bus.tentativas_restantes !== 2'd2)
            begin errors++; $display("FAIL partial_hold[%0d] got estado=%h acertos=%0d tent=%0d want d 2 2", k, bus.estado, bus.acertos, bus.tentativas_restantes); end
      end
      cyc(4'd0, 1'b0, 1'b0);
      checks++; if (bus.estado !== C_PAL || bus.digito !== 4'hF || bus.acertos !== 3'd2)
         begin errors++; $display("FAIL partial_back got estado=%h digito=%h acertos=%0d want 2 f 2", bus.estado, bus.digito, bus.acertos); end
      enter4(16'h5678);
      cyc(4'd0, 1'b0, 1'b0);
      for (int k = 0; k < TEMPO; k++) begin
         checks++; if (bus.estado !== C_FA || bus.acertos !== 3'd0 || bus.tentativas_restantes !== 2'd1)
            begin errors++; $display("FAIL timed_fail[%0d] got estado=%h acertos=%0d tent=%0d want e 0 1", k, bus.estado, bus.acertos, bus.tentativas_restantes); end
         cyc(4'd0, 1'b0, 1'b0);
      end
      checks++; if (bus.estado !== C_PAL) begin errors++; $display("FAIL timed_fail_back got %h want %h", bus.estado, C_PAL); end
   endtask

   task automatic test_exhausted();
      enter4(16'h1111);
      cyc(4'd0, 1'b0, 1'b0);
      checks++; if (bus.estado !== C_FA || bus.tentativas_restantes !== 2'd0 || bus.acertos !== 3'd1)
         begin errors++; $display("FAIL exhausted got estado=%h tent=%0d acertos=%0d want e 0 1", bus.estado, bus.tentativas_restantes, bus.acertos); end
      for (int k = 0; k < 10; k++) begin
         cyc(4'd5, 1'b1, 1'b0);
         checks++; if (bus.estado !== C_FA || bus.digito !== 4'd1 || bus.tentativas_restantes !== 2'd0)
            begin errors++; $display("FAIL exhausted_hold[%0d] got estado=%h digito=%h tent=%0d want e 1 0", k, bus.estado, bus.digito, bus.tentativas_restantes); end
      end
   endtask

   task automatic test_priority();
      cyc(4'd0, 1'b0, 1'b1);
      enter4(16'h1234);
      cyc(4'd7, 1'b1, 1'b0);
      checks++; if (bus.digito !== 4'd7) begin errors++; $display("FAIL prio_digit got %h want 7", bus.digito); end
      cyc(4'd9, 1'b1, 1'b1);
      checks++; if (bus.estado !== C_CAD || bus.digito !== 4'hF)
         begin errors++; $display("FAIL prio_confirma got estado=%h digito=%h want 1 f", bus.estado, bus.digito); end
      enter4(16'h1234);
      checks++; if (bus.estado !== C_PAL) begin errors++; $display("FAIL prio_reentry got %h want %h", bus.estado, C_PAL); end
      enter4(16'h9999);
      for (int k = 0; k < TEMPO; k++) cyc(4'd0, 1'b0, 1'b0);
      checks++; if (bus.estado !== C_FA) begin errors++; $display("FAIL prio_last_timer got %h want %h", bus.estado, C_FA); end
      cyc(4'd5, 1'b1, 1'b1);
      checks++; if (bus.estado !== C_CAD || bus.digito !== 4'hF || bus.tentativas_restantes !== 2'd3 || bus.acertos !== 3'd0)
         begin errors++; $display("FAIL prio_timer got estado=%h digito=%h tent=%0d acertos=%0d want 1 f 3 0", bus.estado, bus.digito, bus.tentativas_restantes, bus.acertos); end
   endtask

   task automatic test_random();
      logic [3:0] e;
      logic       c, r;
      cyc(4'd0, 1'b0, 1'b1);
      for (int k = 0; k < 1500; k++) begin
         r = ($urandom_range(0, 199) == 0);
         c = ($urandom_range(0, 1) == 1);
         e = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(1, 3));
         cyc(e, c, r);
         checks++;
         if (bus.estado !== m_estado || bus.digito !== m_digito ||
             bus.acertos !== 3'(m_acertos) || bus.tentativas_restantes !== 2'(m_tent)) begin
            errors++;
            $display("FAIL random[%0d] got estado=%h digito=%h acertos=%0d tent=%0d want %h %h %0d %0d",
                     k, bus.estado, bus.digito, bus.acertos, bus.tentativas_restantes,
                     m_estado, m_digito, m_acertos, m_tent);
         end
         // Restart after terminal states so the run keeps exercising play.
         if (m_estado == C_ST || (m_estado == C_FA && m_tent == 0)) begin
            if ($urandom_range(0, 3) == 0) cyc(4'd0, 1'b0, 1'b1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_entry();
      test_invalid_digit();
      test_full_success();
      test_partial_then_fail();
      test_exhausted();
      test_priority();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
